// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and stream framing sizes.
package boot_pkg;

    typedef enum logic [2:0] {
        StLenLo,
        StLenHi,
        StData,
        StWriteLast,
        StDone,
        StErr
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_BYTES  = 2;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream valid/ready handshake feeding the boot loader.
interface boot_loader_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);

endinterface

// File: rtl/byte_packer.sv
// Assembles little-endian words one byte lane at a time; complete_o strobes with the last lane.
module byte_packer
    import boot_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      valid_i,
    input  logic [7:0]                data_i,
    output logic [WORD_BYTES*8-1:0]   word_o,
    output logic                      complete_o
);

    localparam int unsigned LaneW = $clog2(WORD_BYTES);

    logic [LaneW-1:0]        lane_q, lane_d;
    logic [WORD_BYTES*8-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (valid_i) begin
            word_d[{lane_q, 3'b000} +: 8] = data_i;
            lane_d = lane_q + LaneW'(1);
        end
    end

    // Word output includes the byte arriving this cycle so the write sees the full word.
    assign word_o     = word_d;
    assign complete_o = valid_i && (lane_q == LaneW'(WORD_BYTES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed program image into instruction memory, holding the core in reset
// until the last word has been written.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    boot_loader_if.slave rx,
    input  logic         reload,
    output logic         imem_we,
    output logic [31:0]  imem_addr,
    output logic [31:0]  imem_wd,
    output logic         core_rst,
    output logic         done,
    output logic         err
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS + 1);
    localparam int unsigned LenW = LEN_BYTES * 8;

    state_e          state_q, state_d;
    logic [LenW-1:0] len_q, len_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            imem_we_q, imem_we_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic [31:0]     imem_wd_q, imem_wd_d;
    logic            core_rst_q, core_rst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            restart;
    logic            pack_valid;
    logic            word_complete;
    logic [31:0]     word;
    logic [LenW-1:0] len_full;

    assign rx.rx_ready = !rst && (state_q inside {StLenLo, StLenHi, StData});
    assign accept      = rx.rx_valid && rx.rx_ready;
    assign restart     = reload && (state_q inside {StDone, StErr});
    assign pack_valid  = accept && (state_q == StData);
    assign len_full    = {rx.rx_data, len_q[7:0]};

    byte_packer u_packer (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (restart),
        .valid_i    (pack_valid),
        .data_i     (rx.rx_data),
        .word_o     (word),
        .complete_o (word_complete)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_wd_d   = imem_wd_q;
        unique case (state_q)
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = rx.rx_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d = StDone;
                    end else if (32'(len_full) > DEPTH_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (word_complete) begin
                    imem_wd_d   = word;
                    imem_we_d   = 1'b1;
                    imem_addr_d = BASE_ADDR + (32'(idx_q) << 2);
                    // idx stops at N-1 so it never overruns the declared image length.
                    if (LenW'(idx_q) == len_q - LenW'(1)) begin
                        state_d = StWriteLast;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StWriteLast: state_d = StDone;
            StDone, StErr: begin
                if (reload) begin
                    state_d     = StLenLo;
                    idx_d       = '0;
                    imem_addr_d = BASE_ADDR;
                end
            end
            default: state_d = StLenLo;
        endcase
        // Status rises one cycle into DONE/ERR and drops on the same edge that leaves it.
        done_d     = (state_q == StDone) && (state_d == StDone);
        err_d      = (state_q == StErr) && (state_d == StErr);
        core_rst_d = !done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLenLo;
            len_q       <= '0;
            idx_q       <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= BASE_ADDR;
            imem_wd_q   <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_wd_q   <= imem_wd_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign imem_wd   = imem_wd_q;
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued by the stimulus and
// popped by a monitor whenever the loader pulses imem_we.
module tb_boot_loader;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        core_rst;
    logic        done;
    logic        err;

    boot_loader_if rx_if ();

    boot_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if),
        .reload    (reload),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   gaps = 1'b0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (imem_we) begin
            check("we_back_to_back", {31'b0, prev_we}, 32'h0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write",
                         imem_addr, imem_wd);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", imem_addr, e.addr);
                check("write_data", imem_wd, e.wd);
            end
        end
        prev_we = imem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = b;
        while (!rx_if.rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_if.rx_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready 0, expected 1", b);
        end
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
        exp_t e;
        e.addr = addr;
        e.wd   = w;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check(name, {31'b0, done}, 32'h1);
    endtask

    initial begin
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("ready_during_rst", {31'b0, rx_if.rx_ready}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_we", {31'b0, imem_we}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wd", imem_wd, 32'h0);
        check("rst_core_rst", {31'b0, core_rst}, 32'h1);
        check("rst_done_err", {30'b0, done, err}, 32'h0);
        check("rst_ready", {31'b0, rx_if.rx_ready}, 32'h1);

        // 1: single word, exact release latency
        send_hdr(16'd1);
        send_word(32'h0, 32'h00A00513);
        check("t1_core_rst_k", {31'b0, core_rst}, 32'h1);
        @(negedge clk);
        check("t1_core_rst_k1", {31'b0, core_rst}, 32'h1);
        check("t1_done_k1", {31'b0, done}, 32'h0);
        @(negedge clk);
        check("t1_core_rst_k2", {31'b0, core_rst}, 32'h0);
        check("t1_done_k2", {31'b0, done}, 32'h1);

        // 2: three words with stalls on rx_valid
        pulse_reload();
        check("t2_reload_core_rst", {31'b0, core_rst}, 32'h1);
        gaps = 1'b1;
        send_hdr(16'd3);
        send_word(32'h0, 32'h00000013);
        send_word(32'h4, 32'hDEADBEEF);
        send_word(32'h8, 32'h12345678);
        gaps = 1'b0;
        wait_done("t2_done");
        check("t2_all_written", 32'(exp_q.size()), 32'h0);

        // 3: empty image
        pulse_reload();
        send_hdr(16'd0);
        check("t3_ready_low", {31'b0, rx_if.rx_ready}, 32'h0);
        @(negedge clk);
        check("t3_done", {31'b0, done}, 32'h1);
        check("t3_core_rst", {31'b0, core_rst}, 32'h0);

        // 6: reload with a byte offered must not consume it
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = 8'h02;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        rx_if.rx_valid = 1'b0;
        check("t6_core_rst", {31'b0, core_rst}, 32'h1);
        check("t6_done", {31'b0, done}, 32'h0);
        send_hdr(16'd1);
        send_word(32'h0, 32'hCAFEF00D);
        wait_done("t6_done_again");

        // 4: oversize header
        pulse_reload();
        send_hdr(16'(DEPTH + 1));
        @(negedge clk);
        check("t4_err", {31'b0, err}, 32'h1);
        check("t4_ready", {31'b0, rx_if.rx_ready}, 32'h0);
        check("t4_core_rst", {31'b0, core_rst}, 32'h1);
        pulse_reload();
        check("t4_err_cleared", {31'b0, err}, 32'h0);
        check("t4_ready_back", {31'b0, rx_if.rx_ready}, 32'h1);

        // Boundary: N == DEPTH fills memory exactly
        send_hdr(16'(DEPTH));
        for (int i = 0; i < DEPTH; i++) send_word(32'(4 * i), (32'(i) * 32'h01010101) ^ 32'h80000001);
        wait_done("full_done");
        check("full_last_addr", imem_addr, 32'(4 * (DEPTH - 1)));
        check("full_err", {31'b0, err}, 32'h0);
        pulse_reload();

        // 5: reset mid-load discards the partial word
        send_hdr(16'd2);
        send_word(32'h0, 32'h11111111);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_addr", imem_addr, 32'h0);
        check("t5_we", {31'b0, imem_we}, 32'h0);
        check("t5_core_rst", {31'b0, core_rst}, 32'h1);
        check("t5_ready", {31'b0, rx_if.rx_ready}, 32'h1);
        send_hdr(16'd1);
        send_word(32'h0, 32'h00112233);
        wait_done("t5_done");

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
